// File: rtl/fifo36_pkg.sv
// Shared word layout, state encoding and sizing helpers for the 36-bit FIFO arbiters.
package fifo36_pkg;

  localparam int unsigned WORD_W  = 36;
  localparam int unsigned SOF_BIT = 32;
  localparam int unsigned EOF_BIT = 33;
  localparam int unsigned OCC_LSB = 34;
  localparam int unsigned SPACE_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  typedef struct packed {
    logic [1:0]  occ;
    logic        eof;
    logic        sof;
    logic [31:0] payload;
  } word_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo36_rr_mux_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping modulo N.
module rr_pick
  import fifo36_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(last_i) + i) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo36_rr_mux.sv
// Packet-atomic round-robin mux in front of the 36-bit FIFO write port; grant is held
// from the grant cycle until the EOF word transfers.
module fifo36_rr_mux
  import fifo36_pkg::*;
#(
  parameter int unsigned NUM_IN    = 4,
  parameter logic [15:0] MIN_SPACE = 16'd0
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [WORD_W*NUM_IN-1:0] data_i,
  input  logic [NUM_IN-1:0]        src_rdy_i,
  output logic [NUM_IN-1:0]        dst_rdy_o,
  output logic [WORD_W-1:0]        data_o,
  output logic                     src_rdy_o,
  input  logic                     dst_rdy_i,
  input  logic [SPACE_W-1:0]       space_i,
  output logic [NUM_IN-1:0]        grant_o,
  output logic                     busy_o
);

  localparam int unsigned IW = idx_w(NUM_IN);

  state_e              state_q, state_d;
  logic [NUM_IN-1:0]   grant_q, grant_d;
  logic [IW-1:0]       sel_q, sel_d;
  logic [IW-1:0]       last_q, last_d;

  word_t               words [NUM_IN];
  word_t               word_sel;
  logic [SPACE_W:0]    space_diff;
  logic                space_ok;
  logic [NUM_IN-1:0]   req;
  logic [NUM_IN-1:0]   pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_vld;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
    assign words[k] = word_t'(data_i[k*WORD_W +: WORD_W]);
  end

  // Sign bit of space_i - MIN_SPACE; avoids a constant compare when the threshold is 0.
  assign space_diff = (SPACE_W+1)'(space_i) - (SPACE_W+1)'(MIN_SPACE);
  assign space_ok   = ~space_diff[SPACE_W];
  assign req        = space_ok ? src_rdy_i : '0;
  assign word_sel   = words[sel_q];

  rr_pick #(
    .N  (NUM_IN),
    .IW (IW)
  ) u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  // Datapath steering from the registered selection; nothing moves while idle.
  always_comb begin
    data_o    = '0;
    src_rdy_o = 1'b0;
    dst_rdy_o = '0;
    if (state_q == ST_PKT) begin
      data_o           = word_sel;
      src_rdy_o        = src_rdy_i[sel_q];
      dst_rdy_o[sel_q] = dst_rdy_i;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_PKT;
          grant_d = pick_gnt;
          sel_d   = pick_idx;
        end
      end
      ST_PKT: begin
        if (src_rdy_o && dst_rdy_i && word_sel.eof) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = sel_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= IW'(NUM_IN - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == ST_PKT);

endmodule
